// File: rtl/param_reg_file.sv
// Parametrised 2R/1W register file with optional zero register, write-first
// bypass and a valid/ready debug dump engine that streams every register.

module param_reg_file_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] q_d, q_q;

  always_comb q_d = we ? wdata : q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

module param_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DEPTH-1:0]             wr_hit;
  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic                         wr_ok;

  // Register 0 under ZERO_REG never sees a write enable, so its flop stays 0
  // and every read path gets the zero rule for free.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_reg
      assign wr_hit[g] = RegWrite && (WriteRegister == ADDR_W'(g)) &&
                         !((ZERO_REG != 0) && (g == 0));
      param_reg_file_cell #(.DATA_W(DATA_W)) u_cell (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_hit[g]),
        .wdata (WriteData),
        .q     (regs[g])
      );
    end
  endgenerate

  // Out-of-range addresses match no entry and fall through to 0.
  function automatic logic [DATA_W-1:0] rd_mux(
    input logic [DEPTH-1:0][DATA_W-1:0] r,
    input logic [ADDR_W-1:0]            a
  );
    rd_mux = '0;
    for (int i = 0; i < DEPTH; i++)
      if (a == ADDR_W'(i)) rd_mux = r[i];
  endfunction

  assign wr_ok = |wr_hit;

  always_comb begin
    ReadData1 = rd_mux(regs, ReadRegister1);
    ReadData2 = rd_mux(regs, ReadRegister2);
    if ((BYPASS != 0) && wr_ok && (WriteRegister == ReadRegister1)) ReadData1 = WriteData;
    if ((BYPASS != 0) && wr_ok && (WriteRegister == ReadRegister2)) ReadData2 = WriteData;
  end

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] ptr_d, ptr_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (dump_start) begin
        state_d = SEND;
        ptr_d   = '0;
      end
      SEND: if (dump_ready) begin
        if (ptr_q == LAST) begin
          state_d = DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Dump data is the stored value only; a same-cycle write shows up next cycle.
  always_comb begin
    dump_busy  = (state_q != IDLE);
    dump_valid = (state_q == SEND);
    dump_done  = (state_q == DONE);
    dump_addr  = '0;
    dump_data  = '0;
    if (state_q == SEND) begin
      dump_addr = ptr_q;
      dump_data = rd_mux(regs, ptr_q);
    end
  end
endmodule

// File: tb/tb_param_reg_file.sv
// Self-checking bench: three configurations (default, no-bypass, 16-deep)
// driven in parallel and compared against array-based reference models.

module tb_param_reg_file;
  logic        clk, rst;
  logic [4:0]  rr1, rr2, wr;
  logic        RegWrite;
  logic [31:0] wd;
  logic        dump_start, dump_ready;

  logic [31:0] rd1 [3];
  logic [31:0] rd2 [3];
  logic [2:0]  d_busy, d_valid, d_done;
  logic [4:0]  d_addr [3];
  logic [31:0] d_data [3];

  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic [31:0] m2 [16];

  int checks = 0;
  int errors = 0;

  param_reg_file u0 (
    .clk(clk), .rst(rst), .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1[0]), .ReadData2(rd2[0]), .RegWrite(RegWrite),
    .WriteRegister(wr), .WriteData(wd), .dump_start(dump_start),
    .dump_busy(d_busy[0]), .dump_valid(d_valid[0]), .dump_ready(dump_ready),
    .dump_addr(d_addr[0]), .dump_data(d_data[0]), .dump_done(d_done[0]));

  param_reg_file #(.BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1[1]), .ReadData2(rd2[1]), .RegWrite(RegWrite),
    .WriteRegister(wr), .WriteData(wd), .dump_start(1'b0),
    .dump_busy(d_busy[1]), .dump_valid(d_valid[1]), .dump_ready(dump_ready),
    .dump_addr(d_addr[1]), .dump_data(d_data[1]), .dump_done(d_done[1]));

  param_reg_file #(.DEPTH(16)) u2 (
    .clk(clk), .rst(rst), .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1[2]), .ReadData2(rd2[2]), .RegWrite(RegWrite),
    .WriteRegister(wr), .WriteData(wd), .dump_start(1'b0),
    .dump_busy(d_busy[2]), .dump_valid(d_valid[2]), .dump_ready(dump_ready),
    .dump_addr(d_addr[2]), .dump_data(d_data[2]), .dump_done(d_done[2]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m0[i] = 0;
      m1[i] = 0;
      if (i < 16) m2[i] = 0;
    end
  endfunction

  // Expected combinational read for configuration inst at address a.
  function automatic logic [31:0] mread(int inst, logic [4:0] a);
    int depth;
    depth = (inst == 2) ? 16 : 32;
    if (int'(a) >= depth || a == 0) return 32'h0;
    if (inst != 1 && RegWrite && wr == a) return wd;
    if (inst == 0) return m0[a];
    if (inst == 1) return m1[a];
    return m2[a[3:0]];
  endfunction

  function automatic logic [31:0] mdump(logic [4:0] a);
    return (a == 0) ? 32'h0 : m0[a];
  endfunction

  // One clock: the models commit whatever was applied during this cycle.
  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else if (RegWrite && wr != 0) begin
      m0[wr] = wd;
      m1[wr] = wd;
      if (wr < 16) m2[wr[3:0]] = wd;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; RegWrite = 0; wr = 0; wd = 0; rr1 = 5; rr2 = 31;
    dump_start = 0; dump_ready = 0;
    model_clear();
    #12;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd1[k] !== 32'h0 || rd2[k] !== 32'h0) begin
        errors++; $display("FAIL reset_read inst%0d got %h/%h want 0", k, rd1[k], rd2[k]);
      end
      checks++;
      if (d_busy[k] !== 1'b0 || d_valid[k] !== 1'b0 || d_done[k] !== 1'b0 ||
          d_addr[k] !== 5'd0 || d_data[k] !== 32'h0) begin
        errors++; $display("FAIL reset_dump inst%0d busy=%b valid=%b done=%b addr=%0d data=%h want all 0",
                           k, d_busy[k], d_valid[k], d_done[k], d_addr[k], d_data[k]);
      end
    end
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  task automatic test_write_read();
    RegWrite = 1; wr = 5; wd = 32'hDEADBEEF;
    tick();
    RegWrite = 0; rr1 = 5; rr2 = 5; #1;
    checks++;
    if (rd1[0] !== 32'hDEADBEEF || rd2[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read r5 got %h/%h want deadbeef", rd1[0], rd2[0]);
    end
    RegWrite = 1; wr = 0; wd = 32'hFFFF_FFFF;
    tick();
    RegWrite = 0; rr1 = 0; rr2 = 0; #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd1[k] !== 32'h0 || rd2[k] !== 32'h0) begin
        errors++; $display("FAIL zero_reg inst%0d got %h/%h want 0", k, rd1[k], rd2[k]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] old;
    old = m1[7];
    RegWrite = 1; wr = 7; wd = 32'h12345678; rr1 = 7; rr2 = 5; #1;
    checks++;
    if (rd1[0] !== 32'h12345678) begin
      errors++; $display("FAIL bypass_on got %h want 12345678", rd1[0]);
    end
    checks++;
    if (rd1[1] !== old) begin
      errors++; $display("FAIL bypass_off_same got %h want %h", rd1[1], old);
    end
    checks++;
    if (rd2[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_other_port got %h want deadbeef", rd2[0]);
    end
    tick();
    RegWrite = 0; #1;
    checks++;
    if (rd1[1] !== 32'h12345678) begin
      errors++; $display("FAIL bypass_off_next got %h want 12345678", rd1[1]);
    end
  endtask

  task automatic test_depth();
    RegWrite = 1; wr = 20; wd = 32'hA5A5_0020; rr1 = 20; rr2 = 20; #1;
    checks++;
    if (rd1[2] !== 32'h0) begin
      errors++; $display("FAIL depth_no_bypass got %h want 0", rd1[2]);
    end
    tick();
    RegWrite = 0; #1;
    checks++;
    if (rd1[2] !== 32'h0 || rd2[2] !== 32'h0) begin
      errors++; $display("FAIL depth_oob_read got %h/%h want 0", rd1[2], rd2[2]);
    end
    checks++;
    if (rd1[0] !== 32'hA5A5_0020) begin
      errors++; $display("FAIL depth_full_r20 got %h want a5a50020", rd1[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      RegWrite = ($urandom_range(0, 3) != 0);
      wr  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      rr1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      rr2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd1[k] !== mread(k, rr1) || rd2[k] !== mread(k, rr2)) begin
          errors++; $display("FAIL random inst%0d rr1=%0d rr2=%0d got %h/%h want %h/%h",
                             k, rr1, rr2, rd1[k], rd2[k], mread(k, rr1), mread(k, rr2));
        end
      end
      tick();
    end
    RegWrite = 0;
  endtask

  task automatic test_dump_full();
    for (int i = 0; i < 32; i++) begin
      RegWrite = 1; wr = 5'(i); wd = 32'(i * 3);
      tick();
    end
    RegWrite = 0; dump_ready = 1; dump_start = 1;
    tick();
    dump_start = 0;
    for (int n = 1; n <= 34; n++) begin
      if (n <= 32) begin
        checks++;
        if (d_valid[0] !== 1'b1 || d_addr[0] !== 5'(n - 1) || d_data[0] !== 32'((n - 1) * 3) ||
            d_done[0] !== 1'b0) begin
          errors++; $display("FAIL dump_beat cyc%0d valid=%b addr=%0d data=%0d done=%b want 1/%0d/%0d/0",
                             n, d_valid[0], d_addr[0], d_data[0], d_done[0], n - 1, (n - 1) * 3);
        end
      end else if (n == 33) begin
        checks++;
        if (d_done[0] !== 1'b1 || d_valid[0] !== 1'b0 || d_busy[0] !== 1'b1) begin
          errors++; $display("FAIL dump_done_cyc33 done=%b valid=%b busy=%b want 1/0/1",
                             d_done[0], d_valid[0], d_busy[0]);
        end
      end else begin
        checks++;
        if (d_done[0] !== 1'b0 || d_busy[0] !== 1'b0) begin
          errors++; $display("FAIL dump_idle_after done=%b busy=%b want 0/0", d_done[0], d_busy[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_dump_stall();
    int  idx;
    int  ndone;
    bit  finished;
    idx = 0; ndone = 0; finished = 0;
    dump_start = 1; dump_ready = 0;
    tick();
    dump_start = 0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      dump_ready = cyc[0];
      dump_start = (cyc == 9 || cyc == 40);
      // On a stalled beat, rewrite the register being shown: visible only next cycle.
      RegWrite = !dump_ready && d_valid[0];
      wr = 5'(idx);
      wd = $urandom;
      #1;
      if (d_valid[0]) begin
        checks++;
        if (d_addr[0] !== 5'(idx) || d_data[0] !== mdump(5'(idx))) begin
          errors++; $display("FAIL dump_stall beat got addr=%0d data=%h want %0d/%h",
                             d_addr[0], d_data[0], idx, mdump(5'(idx)));
        end
        if (dump_ready) idx++;
      end
      if (d_done[0]) begin
        ndone++;
        finished = 1;
      end
      tick();
    end
    RegWrite = 0; dump_start = 0;
    checks++;
    if (idx != 32 || ndone != 1 || d_busy[0] !== 1'b0) begin
      errors++; $display("FAIL dump_stall_total beats=%0d done=%0d busy=%b want 32/1/0",
                         idx, ndone, d_busy[0]);
    end
  endtask

  task automatic test_reset_mid_dump();
    dump_ready = 1; dump_start = 1;
    tick();
    dump_start = 0;
    repeat (10) tick();
    checks++;
    if (d_addr[0] !== 5'd10 || d_valid[0] !== 1'b1) begin
      errors++; $display("FAIL mid_dump_pos addr=%0d valid=%b want 10/1", d_addr[0], d_valid[0]);
    end
    rst = 1; model_clear(); rr1 = 9; rr2 = 31; #1;
    checks++;
    if (d_busy[0] !== 1'b0 || d_valid[0] !== 1'b0 || d_done[0] !== 1'b0 ||
        d_addr[0] !== 5'd0 || d_data[0] !== 32'h0) begin
      errors++; $display("FAIL mid_reset_dump busy=%b valid=%b done=%b addr=%0d data=%h want 0",
                         d_busy[0], d_valid[0], d_done[0], d_addr[0], d_data[0]);
    end
    checks++;
    if (rd1[0] !== 32'h0 || rd2[0] !== 32'h0 || rd1[1] !== 32'h0) begin
      errors++; $display("FAIL mid_reset_regs got %h/%h/%h want 0", rd1[0], rd2[0], rd1[1]);
    end
    tick();
    rst = 0;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (d_done[0] !== 1'b0 || d_busy[0] !== 1'b0) begin
        errors++; $display("FAIL no_done_after_reset done=%b busy=%b want 0/0", d_done[0], d_busy[0]);
      end
      tick();
    end
    RegWrite = 1; wr = 1; wd = 32'h0000_BEEF;
    tick();
    RegWrite = 0; dump_start = 1;
    tick();
    dump_start = 0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (d_valid[0] !== 1'b1 || d_addr[0] !== 5'(n) || d_data[0] !== mdump(5'(n))) begin
        errors++; $display("FAIL redump beat%0d valid=%b addr=%0d data=%h want 1/%0d/%h",
                           n, d_valid[0], d_addr[0], d_data[0], n, mdump(5'(n)));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_depth();
    test_random();
    test_dump_full();
    test_dump_stall();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
